// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the RAM port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CPU_SETUP  = 3'd1,
    CPU_ACCESS = 3'd2,
    LD_SETUP   = 3'd3,
    LD_ACCESS  = 3'd4
  } state_t;

  // True in either ACCESS cycle: the only cycles where the RAM is enabled.
  function automatic logic is_access(input state_t s);
    return (s == CPU_ACCESS) || (s == LD_ACCESS);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between CPU and loader, plus the loader burst counter
// that bounds how long a pending CPU request can be starved.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int LD_MAX_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic decide,
  input  logic cpu_req,
  input  logic ld_req,
  output logic grant_cpu,
  output logic grant_ld
);

  localparam int CNT_W = $clog2(LD_MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(LD_MAX_BURST);

  logic [CNT_W-1:0] burst_cnt_r;
  logic             burst_full_s;

  assign burst_full_s = (burst_cnt_r == BURST_MAX);

  // Pick a winner at a decision point; loader first unless its burst is spent.
  always_comb begin
    grant_cpu = 1'b0;
    grant_ld  = 1'b0;
    if (decide) begin
      if (ld_req && !(cpu_req && burst_full_s)) begin
        grant_ld = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end else begin
        grant_ld = 1'b0;
      end
    end else begin
      grant_cpu = 1'b0;
    end
  end

  // Count loader grants made while the CPU waits; any CPU grant or idle CPU clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt_r <= {CNT_W{1'b0}};
    end else if (!cpu_req || grant_cpu) begin
      burst_cnt_r <= {CNT_W{1'b0}};
    end else if (grant_ld && !burst_full_s) begin
      burst_cnt_r <= burst_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      burst_cnt_r <= burst_cnt_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester RAM port arbiter: each transfer is a SETUP cycle (address and
// data driven) followed by an ACCESS cycle (enable and done asserted).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int LD_MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_oe,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t state_r;
  state_t state_nx_s;
  logic   access_s;
  logic   decide_s;
  logic   grant_cpu_s;
  logic   grant_ld_s;
  logic   op_we_r;

  assign access_s = is_access(state_r);
  assign decide_s = (state_r == IDLE) || access_s;

  mem_arb_pick #(
    .LD_MAX_BURST(LD_MAX_BURST)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .decide   (decide_s),
    .cpu_req  (cpu_req),
    .ld_req   (ld_req),
    .grant_cpu(grant_cpu_s),
    .grant_ld (grant_ld_s)
  );

  // Next state: SETUP always advances to ACCESS; decision states follow the grant.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      CPU_SETUP: state_nx_s = CPU_ACCESS;
      LD_SETUP:  state_nx_s = LD_ACCESS;
      IDLE, CPU_ACCESS, LD_ACCESS: begin
        if (grant_ld_s) begin
          state_nx_s = LD_SETUP;
        end else if (grant_cpu_s) begin
          state_nx_s = CPU_SETUP;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register; reset drops any in-flight transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Latch the winner's request on SETUP entry; requester inputs are ignored afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr  <= {ADDR_W{1'b0}};
      ram_wdata <= {DATA_W{1'b0}};
      op_we_r   <= 1'b0;
    end else if (grant_ld_s) begin
      ram_addr  <= ld_addr;
      ram_wdata <= ld_wdata;
      op_we_r   <= ld_we;
    end else if (grant_cpu_s) begin
      ram_addr  <= cpu_addr;
      ram_wdata <= cpu_wdata;
      op_we_r   <= cpu_we;
    end else begin
      ram_addr  <= ram_addr;
      ram_wdata <= ram_wdata;
      op_we_r   <= op_we_r;
    end
  end

  // Capture read data on the edge that ends a read ACCESS; writes leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata <= {DATA_W{1'b0}};
      ld_rdata  <= {DATA_W{1'b0}};
    end else if ((state_r == CPU_ACCESS) && !op_we_r) begin
      cpu_rdata <= ram_rdata;
    end else if ((state_r == LD_ACCESS) && !op_we_r) begin
      ld_rdata <= ram_rdata;
    end else begin
      cpu_rdata <= cpu_rdata;
      ld_rdata  <= ld_rdata;
    end
  end

  // Enables and done pulses decode straight from the state register, so they
  // are glitch-free and exactly one ACCESS cycle wide.
  assign ram_we    = access_s & op_we_r;
  assign ram_oe    = access_s & ~op_we_r;
  assign cpu_done  = (state_r == CPU_ACCESS);
  assign ld_done   = (state_r == LD_ACCESS);
  assign cpu_stall = cpu_req & (state_r != CPU_ACCESS);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus randomized two-requester traffic against a
// transaction-level reference model.
module tb_mem_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, ld_req, ld_we;
  logic [7:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
  logic       cpu_done, cpu_stall, ld_done, ram_we, ram_oe;
  logic [7:0] cpu_rdata, ld_rdata, ram_addr, ram_wdata, ram_rdata;

  logic [7:0] dmem [256];
  logic [7:0] mmem [256];

  int checks = 0;
  int errors = 0;

  // Reference model: transaction phase (0 idle, 2 setup, 1 access), owner (0 cpu, 1 loader)
  int         m_busy, m_owner, m_burst;
  logic       m_we;
  logic [7:0] m_addr, m_wdata, m_cpu_rd, m_ld_rd;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LD_MAX_BURST(MAXB)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_rdata(ld_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM attached to the DUT
  always @(posedge clk) if (ram_we) dmem[ram_addr] <= ram_wdata;
  assign ram_rdata = dmem[ram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_burst = 0; m_we = 1'b0;
    m_addr = 8'h00; m_wdata = 8'h00; m_cpu_rd = 8'h00; m_ld_rd = 8'h00;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    int win;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_busy == 1) begin
      if (m_we) mmem[m_addr] = m_wdata;
      else if (m_owner == 0) m_cpu_rd = mmem[m_addr];
      else m_ld_rd = mmem[m_addr];
    end
    win = -1;
    if (m_busy != 2) begin
      if (ld_req && cpu_req) win = (m_burst == MAXB) ? 0 : 1;
      else if (ld_req) win = 1;
      else if (cpu_req) win = 0;
    end
    if (!cpu_req || win == 0) m_burst = 0;
    else if (win == 1 && m_burst < MAXB) m_burst++;
    if (m_busy == 2) m_busy = 1;
    else if (win < 0) m_busy = 0;
    else begin
      m_busy = 2; m_owner = win;
      m_we    = (win == 1) ? ld_we : cpu_we;
      m_addr  = (win == 1) ? ld_addr : cpu_addr;
      m_wdata = (win == 1) ? ld_wdata : cpu_wdata;
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic compare();
    logic acc;
    acc = (m_busy == 1);
    check("cpu_done", cpu_done, acc && m_owner == 0);
    check("ld_done", ld_done, acc && m_owner == 1);
    check("ram_we", ram_we, acc && m_we);
    check("ram_oe", ram_oe, acc && !m_we);
    check("we_oe_excl", ram_we & ram_oe, 1'b0);
    check("cpu_stall", cpu_stall, cpu_req && !(acc && m_owner == 0));
    check("cpu_rdata", cpu_rdata, m_cpu_rd);
    check("ld_rdata", ld_rdata, m_ld_rd);
    check("ram_addr", ram_addr, m_addr);
    check("ram_wdata", ram_wdata, m_wdata);
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive_random();
    if ($urandom_range(0, 499) == 0) begin
      reset = 1'b1; cpu_req = 1'b0; ld_req = 1'b0;
      return;
    end
    reset = 1'b0;
    if (cpu_req) begin
      if (m_busy == 1 && m_owner == 0) begin
        cpu_req = 1'($urandom_range(0, 1));
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
      end
    end else if ($urandom_range(0, 2) == 0) begin
      cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
    end
    if (ld_req) begin
      if (m_busy == 1 && m_owner == 1) begin
        ld_req = 1'($urandom_range(0, 1));
        ld_we = 1'($urandom_range(0, 1));
        ld_addr = 8'($urandom_range(0, 15)); ld_wdata = 8'($urandom);
      end
    end else if ($urandom_range(0, 2) == 0) begin
      ld_req = 1'b1; ld_we = 1'($urandom_range(0, 1));
      ld_addr = 8'($urandom_range(0, 15)); ld_wdata = 8'($urandom);
    end
  endtask

  initial begin
    int run, maxrun, nev;
    logic [7:0] v;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = 8'h00; ld_wdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      dmem[i] = v; mmem[i] = v;
    end
    dmem[8'h10] = 8'h5A; mmem[8'h10] = 8'h5A;
    dmem[8'h30] = 8'h77; mmem[8'h30] = 8'h77;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    check("rst_ram_addr", ram_addr, 8'h00);
    check("rst_cpu_rdata", cpu_rdata, 8'h00);
    check("rst_state", 32'(u_dut.state_r), 32'd0);
    reset = 1'b0;
    step();

    // CPU-only read of 0x10
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; #1;
    check("t1_stall_c0", cpu_stall, 1'b1);
    step();
    check("t1_stall_c1", cpu_stall, 1'b1);
    check("t1_oe_c1", ram_oe, 1'b0);
    step();
    check("t1_done_c2", cpu_done, 1'b1);
    check("t1_oe_c2", ram_oe, 1'b1);
    check("t1_stall_c2", cpu_stall, 1'b0);
    cpu_req = 1'b0;
    step();
    check("t1_rdata_c3", cpu_rdata, 8'h5A);
    check("t1_done_c3", cpu_done, 1'b0);

    // Loader writes 0xC3 to 0x20, CPU reads it back with no idle bubble
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h20; ld_wdata = 8'hC3;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    step();
    check("t2_ld_done", ld_done, 1'b1);
    check("t2_ld_we", ram_we, 1'b1);
    ld_req = 1'b0;
    step();
    check("t2_cpu_setup_addr", ram_addr, 8'h20);
    step();
    check("t2_cpu_done", cpu_done, 1'b1);
    cpu_req = 1'b0;
    step();
    check("t2_cpu_rdata", cpu_rdata, 8'hC3);

    // Both requesters saturated from IDLE: loader first, then L L L L C pattern
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h21;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h22;
    run = 1; maxrun = 1; nev = 0;
    step();
    check("t4_ld_first_addr", ram_addr, 8'h22);
    check("t4_burst_one", 32'(u_dut.u_pick.burst_cnt_r), 32'd1);
    run = cpu_stall ? run + 1 : 0;
    for (int c = 2; c <= 60; c++) begin
      step();
      run = cpu_stall ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (ld_done || cpu_done) begin
        check("t3_pattern", {31'd0, cpu_done}, (nev % 5 == 4) ? 32'd1 : 32'd0);
        nev++;
      end
    end
    check("t3_events", nev, 30);
    check("t3_max_stall", maxrun, 10);
    cpu_req = 1'b0; ld_req = 1'b0;
    step();
    step();

    // Reset in the middle of a CPU write ACCESS to 0x30
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'hEE;
    step();
    step();
    check("t5_in_access", ram_we, 1'b1);
    reset = 1'b1; cpu_req = 1'b0; #1;
    check("t5_done_low", cpu_done, 1'b0);
    check("t5_we_low", ram_we, 1'b0);
    check("t5_addr_zero", ram_addr, 8'h00);
    check("t5_wdata_zero", ram_wdata, 8'h00);
    model_reset();
    step();
    reset = 1'b0;
    check("t5_mem_kept", dmem[8'h30], 8'h77);
    check("t5_state_idle", 32'(u_dut.state_r), 32'd0);
    step();

    // Randomized back-to-back traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      step();
    end
    reset = 1'b0; cpu_req = 1'b0; ld_req = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 16; i++) check("final_mem", dmem[i], mmem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single RAM port between the CPU microcode path (FSM/control signals c_ro/c_ri) and an external program loader/debug port. It sequences each RAM transfer as a two-cycle setup/access transaction, drives the RAM address, data and enables, and produces a stall for the clock block while the CPU waits. Loader traffic has priority, bounded by a burst limit so the CPU cannot be starved.

## Interface
- ADDR_W, default 8: RAM address width.
- DATA_W, default 8: RAM data width.
- LD_MAX_BURST, default 4: maximum consecutive loader grants while cpu_req is pending. Must be ≥1.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cpu_req  in  1  CPU transfer request; held until cpu_done.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_done  out  1  one-cycle pulse in the CPU ACCESS cycle.
- cpu_rdata  out  DATA_W  registered read data, held until the next CPU read completes.
- cpu_stall  out  1  combinational: cpu_req & ~(state == CPU_ACCESS); feeds halt.
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as CPU.
- ld_done  out  1  one-cycle pulse in the loader ACCESS cycle.
- ld_rdata  out  DATA_W  registered loader read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_rdata  in  DATA_W  RAM read data, valid during ram_oe.

## Operation
- States: IDLE, CPU_SETUP, CPU_ACCESS, LD_SETUP, LD_ACCESS.
- Decision points: IDLE, and the last cycle of either ACCESS state. At a decision point, the winner's SETUP is entered on the next edge. No requester pending means IDLE.
- Winner selection:
  - Only one requester pending: that requester wins.
  - Both pending: loader wins unless burst_cnt == LD_MAX_BURST, in which case the CPU wins.
- burst_cnt (width enough for LD_MAX_BURST):
  - increments on each loader grant while cpu_req = 1;
  - clears on each CPU grant and on any cycle with cpu_req = 0;
  - saturates at LD_MAX_BURST.
- On SETUP entry, latch the winner's addr/wdata/we into ram_addr/ram_wdata/op registers. Requester inputs are ignored after that point.
- SETUP: ram_addr and ram_wdata are driven; ram_we = ram_oe = 0.
- ACCESS: ram_we = op_we, or ram_oe = ~op_we. The matching done signal is high.
  - Reads: ram_rdata is captured into cpu_rdata/ld_rdata on the edge ending ACCESS.
  - Writes leave rdata unchanged.
- A req still high in the cycle after done is a new transaction.
- Requests arriving mid-transaction wait. No preemption.
- Reset, including mid-transaction: state IDLE, burst_cnt 0, all outputs 0 (cpu_stall follows cpu_req). Any in-flight transfer is dropped, with no done and no write.

## Timing
- Latency from req rising in IDLE: SETUP on the next edge, ACCESS (done) one cycle later. Best case is 2 cycles request-to-done; read data is usable in the cycle after done.
- Back-to-back transfers take 2 cycles each with no IDLE bubble, giving a peak of 1 transfer / 2 cycles.
- Worst-case CPU wait with the loader saturated: 2·LD_MAX_BURST cycles plus any in-flight transfer (2).
- ram_we and ram_oe are never both high, and never high outside ACCESS.
- done is registered-state-decoded, glitch-free, and exactly one cycle wide.

## Structure
- Shared package mem_arb_pkg:
  - state enum (5 states above);
  - ADDR_W/DATA_W defaults matching the computer's 8-bit buses.
- Sub-module mem_arb_pick: combinational winner select plus burst_cnt register. The top level holds the state register, latches and rdata registers.

## Test plan
- CPU-only read: ram holds 0x5A at 0x10, cpu_req/addr=0x10 raised in IDLE. Expected: ram_oe high in cycle 2, cpu_done in cycle 2, cpu_rdata=0x5A from cycle 3, cpu_stall high in cycles 0–1.
- Loader write then CPU read same address: loader writes 0xC3 to 0x20, CPU request raised one cycle later. Expected: loader transfer completes first, CPU reads 0xC3, no IDLE cycle between them.
- Starvation bound with LD_MAX_BURST=4: ld_req held high continuously, cpu_req held high. Expected: exactly 4 ld_done pulses, then 1 cpu_done, repeating. cpu_stall is never high for more than 10 consecutive cycles.
- Simultaneous requests from IDLE with burst_cnt=0: loader granted first, burst_cnt becomes 1.
- Reset asserted during CPU_ACCESS write to 0x30. Expected: all outputs 0 immediately (asynchronous), no cpu_done, RAM[0x30] unchanged, state IDLE after release.
- Mutual exclusion check, randomized back-to-back traffic: ram_we & ram_oe is never true, and neither is ever high in SETUP or IDLE.
